// File: rtl/jump_indicator_consumer_pkg.sv
// Shared constants, FSM encoding and instruction helper for the jump-indicator consumer.
// The only instruction built here is the addi that zeroes the indicator register.
package jump_indicator_consumer_pkg;

  localparam logic [4:0] OPC_ADDI     = 5'd5;
  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam logic [4:0] REG_JUMP_IND = 5'd29;
  localparam int unsigned IMM_W       = 17;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CLEAR    = 2'b01,
    ST_AIRBORNE = 2'b10
  } jic_state_e;

  // Field order is opcode, destination, source, immediate.
  function automatic logic [31:0] build_addi(input logic [4:0] dst, input logic [4:0] src);
    return {OPC_ADDI, dst, src, {IMM_W{1'b0}}};
  endfunction

endpackage

// File: rtl/jump_clear_instructionbuilder.sv
// Combinational builder of "addi IND_REG,$0,0", the word that zeroes the indicator.
module jump_clear_instructionbuilder
  import jump_indicator_consumer_pkg::*;
(
  input  logic [4:0]  i_ind_reg,
  output logic [31:0] o_instruction
);

  assign o_instruction = build_addi(i_ind_reg, REG_ZERO);

endmodule

// File: rtl/jump_indicator_consumer.sv
// Snoops writebacks to the jump indicator register, pulses a jump, holds an airborne
// window and injects the instruction that clears the indicator again.
module jump_indicator_consumer
  import jump_indicator_consumer_pkg::*;
#(
  parameter logic [4:0]  IND_REG     = REG_JUMP_IND,
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        inj_ready,
  output logic        inj_valid,
  output logic [31:0] inj_instruction,
  output logic        jump_pulse,
  output logic        jump_active
);

  // A zero-length window skips AIRBORNE entirely.
  localparam logic [CNT_W-1:0] LAST_COUNT =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam jic_state_e POST_CLEAR = (HOLD_CYCLES == 0) ? ST_IDLE : ST_AIRBORNE;
  localparam logic       POST_CLEAR_ACTIVE = (HOLD_CYCLES != 0);

  logic             w_hit;
  logic             w_accept;
  logic [31:0]      w_clear_word;

  jic_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_stale;
  logic             r_inj_valid;
  logic             r_jump_pulse;
  logic             r_jump_active;

  jump_clear_instructionbuilder u_builder (
    .i_ind_reg     (IND_REG),
    .o_instruction (w_clear_word)
  );

  // Zero writes, including our own injected clear, must never look like a key press.
  assign w_hit    = wb_we && (wb_rd == IND_REG) && (wb_data != '0);
  assign w_accept = r_inj_valid && inj_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_stale       <= 1'b0;
      r_inj_valid   <= 1'b0;
      r_jump_pulse  <= 1'b0;
      r_jump_active <= 1'b0;
    end else begin
      r_jump_pulse <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state       <= ST_CLEAR;
            r_stale       <= 1'b0;
            r_inj_valid   <= 1'b1;
            r_jump_pulse  <= 1'b1;
            r_jump_active <= 1'b1;
          end else if (r_stale) begin
            r_state       <= ST_CLEAR;
            r_stale       <= 1'b0;
            r_inj_valid   <= 1'b1;
            r_jump_active <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (w_hit) begin
            r_stale <= 1'b1;
          end
          if (w_accept) begin
            r_state       <= POST_CLEAR;
            r_count       <= '0;
            r_inj_valid   <= 1'b0;
            r_jump_active <= POST_CLEAR_ACTIVE;
          end
        end
        ST_AIRBORNE: begin
          // Extra presses while airborne only owe a clear, never a second jump.
          if (w_hit) begin
            r_stale <= 1'b1;
          end
          if (r_count >= LAST_COUNT) begin
            r_state       <= ST_IDLE;
            r_jump_active <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_count       <= '0;
          r_inj_valid   <= 1'b0;
          r_jump_active <= 1'b0;
        end
      endcase
    end
  end

  assign inj_valid       = r_inj_valid;
  assign inj_instruction = w_clear_word;
  assign jump_pulse      = r_jump_pulse;
  assign jump_active     = r_jump_active;

endmodule

// File: tb/tb_jump_indicator_consumer.sv
// Scoreboard bench for jump_indicator_consumer: a 6-cycle-window build and a zero-window
// build share random writeback traffic and are checked against a countdown model.
module tb_jump_indicator_consumer;

  localparam int unsigned HOLD_A     = 6;
  localparam logic [31:0] CLEAR_WORD = 32'h2F40_0000;

  typedef struct packed {
    logic valid;
    logic pulse;
    logic active;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        inj_ready = 1'b0;

  logic        valid  [2];
  logic [31:0] instr  [2];
  logic        pulse  [2];
  logic        active [2];

  int testsRun  = 0;
  int failCount = 0;
  int cycle     = 0;
  bit checkEn   = 1'b0;

  exp_t sbq0[$];
  exp_t sbq1[$];

  // Model state: a clear still being offered, cycles of window left, a press owed a clear.
  bit needClear [2];
  int airLeft   [2];
  bit owedClear [2];

  jump_indicator_consumer #(.IND_REG(5'd29), .HOLD_CYCLES(HOLD_A), .CNT_W(4)) dutA (
    .clock(clock), .reset_n(reset_n), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .inj_ready(inj_ready), .inj_valid(valid[0]), .inj_instruction(instr[0]),
    .jump_pulse(pulse[0]), .jump_active(active[0])
  );

  jump_indicator_consumer #(.IND_REG(5'd29), .HOLD_CYCLES(0), .CNT_W(4)) dutB (
    .clock(clock), .reset_n(reset_n), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .inj_ready(inj_ready), .inj_valid(valid[1]), .inj_instruction(instr[1]),
    .jump_pulse(pulse[1]), .jump_active(active[1])
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  task automatic compareVal(input string name, input int d, input logic [31:0] act,
                            input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, d, cycle, act, expv);
    end
  endtask

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      needClear[d] = 1'b0;
      airLeft[d]   = 0;
      owedClear[d] = 1'b0;
    end
  endfunction

  // Advances the model by one clock and returns the outputs expected after that edge.
  function automatic exp_t modelStep(input int d, input bit hit, input bit ready);
    exp_t e;
    bit busy;
    bit jumped;
    jumped = 1'b0;
    busy = needClear[d] || (airLeft[d] > 0);
    if (!busy) begin
      if (hit) begin
        needClear[d] = 1'b1;
        owedClear[d] = 1'b0;
        jumped = 1'b1;
      end else if (owedClear[d]) begin
        needClear[d] = 1'b1;
        owedClear[d] = 1'b0;
      end
    end else begin
      if (hit) owedClear[d] = 1'b1;
      if (needClear[d]) begin
        if (ready) begin
          needClear[d] = 1'b0;
          airLeft[d] = (d == 0) ? int'(HOLD_A) : 0;
        end
      end else begin
        airLeft[d]--;
      end
    end
    e.valid  = needClear[d];
    e.pulse  = jumped;
    e.active = needClear[d] || (airLeft[d] > 0);
    return e;
  endfunction

  task automatic pushExpected(input bit hit, input bit ready);
    sbq0.push_back(modelStep(0, hit, ready));
    sbq1.push_back(modelStep(1, hit, ready));
  endtask

  task automatic applyStimulus(input bit we, input logic [4:0] rd, input logic [31:0] data,
                               input bit ready);
    @(posedge clock);
    #1;
    wb_we     = we;
    wb_rd     = rd;
    wb_data   = data;
    inj_ready = ready;
    pushExpected(we && (rd == 5'd29) && (data != 32'd0), ready);
  endtask

  task automatic checkOutput();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL scoreboard dut%0d cycle %0d: got output, expected queue entry", d, cycle);
      end else begin
        if (d == 0) e = sbq0.pop_front();
        else        e = sbq1.pop_front();
        compareVal("inj_valid",       d, {31'd0, valid[d]},  {31'd0, e.valid});
        compareVal("jump_pulse",      d, {31'd0, pulse[d]},  {31'd0, e.pulse});
        compareVal("jump_active",     d, {31'd0, active[d]}, {31'd0, e.active});
        compareVal("inj_instruction", d, instr[d],           CLEAR_WORD);
      end
    end
  endtask

  // Asserts reset between clock edges, checks outputs fell asynchronously, then releases.
  task automatic applyReset();
    @(negedge clock);
    #1;
    checkEn   = 1'b0;
    reset_n   = 1'b0;
    wb_we     = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    inj_ready = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      compareVal("reset_inj_valid",   d, {31'd0, valid[d]},  32'd0);
      compareVal("reset_jump_pulse",  d, {31'd0, pulse[d]},  32'd0);
      compareVal("reset_jump_active", d, {31'd0, active[d]}, 32'd0);
      compareVal("reset_instruction", d, instr[d],           CLEAR_WORD);
    end
    sbq0.delete();
    sbq1.delete();
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    pushExpected(1'b0, 1'b0);
    checkEn = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (checkEn) checkOutput();
    end
  end

  initial begin
    modelReset();
    applyReset();

    // Idle lead-in, then a clean press accepted at once.
    repeat (8) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b1);
    repeat (HOLD_A + 4) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    // Press with the CPU refusing the injected clear for five cycles.
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b0);
    repeat (5) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (HOLD_A + 4) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    // Second press while airborne: no second jump, one extra clear afterwards.
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b1);
    repeat (2) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b1);
    repeat (HOLD_A + 6) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    // Writes that must be ignored.
    applyStimulus(1'b1, 5'd29, 32'd0, 1'b1);
    applyStimulus(1'b1, 5'd28, 32'd1, 1'b1);
    applyStimulus(1'b0, 5'd29, 32'd1, 1'b1);
    repeat (3) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    // Reset mid-CLEAR, recover, then reset mid-AIRBORNE and recover.
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    applyReset();
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b1);
    repeat (3) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    applyReset();
    applyStimulus(1'b1, 5'd29, 32'd1, 1'b1);
    repeat (HOLD_A + 4) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);

    // Randomised traffic biased toward the indicator register.
    for (int i = 0; i < 2500; i++) begin
      bit          we;
      bit          ready;
      logic [4:0]  rd;
      logic [31:0] data;
      we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    rd = 5'd29;
        2:       rd = 5'd28;
        default: rd = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
        0:       data = 32'd0;
        1:       data = 32'd1;
        default: data = $urandom;
      endcase
      ready = ($urandom_range(0, 9) < 6);
      applyStimulus(we, rd, data, ready);
      if ((i % 700) == 350) applyReset();
    end

    repeat (HOLD_A + 5) applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    @(posedge clock);
    #5;
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
